// File: rtl/sprite_pkg.sv
// Shared types and command-word field positions for the sprite command scheduler.
package sprite_pkg;

  localparam int          CMD_ACTION_LSB = 17;
  localparam int          CMD_ACTION_W   = 4;
  localparam int          CMD_TOG_BIT    = 13;
  localparam logic [3:0]  ACTION_SWAP    = 4'hF;
  localparam logic [31:0] CMD_IDLE       = 32'h0;

  typedef struct packed {
    logic        is_commit;
    logic [31:0] word;
  } sched_entry_t;

  typedef enum logic {ST_RUN, ST_SWAP_WAIT} sched_state_e;

  // Buffer-swap broadcast word: only the action field and the target buffer bit are set.
  function automatic logic [31:0] swap_word(input logic tog);
    logic [31:0] w;
    w = CMD_IDLE;
    w[CMD_ACTION_LSB +: CMD_ACTION_W] = ACTION_SWAP;
    w[CMD_TOG_BIT] = tog;
    return w;
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x 33) with occupancy count; push while full is honoured
// only when a pop frees the head slot in the same cycle.
module sched_cmd_fifo
  import sprite_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  sched_entry_t  din_i,
  output sched_entry_t  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  sched_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Avalon-MM command scheduler: queues host commands, retargets them to the back buffer and
// issues buffer swaps only inside vblank. Optional interrupt enabled by SPRITE_SCHED_IRQ_EN.
module sprite_cmd_scheduler
  import sprite_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int VBLANK_START = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf,
  output logic        irq
);

  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] VB_LINE = 10'(VBLANK_START);

  sched_state_e  state_q, state_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          front_q, front_d;
  logic          swap_done_q, swap_done_d;
  logic          ovf_q, ovf_d;

  logic          wr_acc, push, pop, clr_flags, vblank, do_swap;
  logic          full, empty;
  logic [CW-1:0] count;
  sched_entry_t  push_ent, head;

  assign wr_acc             = chipselect && write;
  assign push               = wr_acc && (address == 2'd0 || address == 2'd1);
  assign clr_flags          = wr_acc && (address == 2'd2);
  assign push_ent.is_commit = (address == 2'd1);
  assign push_ent.word      = push_ent.is_commit ? CMD_IDLE : writedata;
  assign vblank             = (vcount >= VB_LINE);

  sched_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_n_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A commit at the head blocks everything behind it until its swap has been issued.
  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_IDLE;
    front_d = front_q;
    pop     = 1'b0;
    do_swap = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!empty) begin
          if (head.is_commit) begin
            state_d = ST_SWAP_WAIT;
          end else begin
            pop                = 1'b1;
            cmd_d              = head.word;
            cmd_d[CMD_TOG_BIT] = ~front_q;
          end
        end
      end
      ST_SWAP_WAIT: begin
        if (vblank && !swap_done_q) begin
          pop     = 1'b1;
          do_swap = 1'b1;
          cmd_d   = swap_word(~front_q);
          front_d = ~front_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // One swap per vblank: the latch re-arms only once the beam has left vblank.
  always_comb begin
    swap_done_d = do_swap ? 1'b1 : (vblank ? swap_done_q : 1'b0);
    ovf_d       = (push && full && !pop) ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cmd_q       <= CMD_IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef SPRITE_SCHED_IRQ_EN
  logic irq_q, irq_d, rd_seen_q;

  // Read clears one cycle after the access; a swap in that same cycle keeps irq set.
  always_comb irq_d = do_swap ? 1'b1 : ((clr_flags || rd_seen_q) ? 1'b0 : irq_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      rd_seen_q <= chipselect && read;
    end
  end

  assign irq = irq_q;
`else
  logic unused_rd;
  assign unused_rd = read;
  assign irq       = 1'b0;
`endif

  assign cmd_out   = cmd_q;
  assign front_buf = front_q;
  assign readdata  = {16'b0, 8'(count), 4'b0, (state_q == ST_SWAP_WAIT), front_q, ovf_q, irq};

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Self-checking bench for sprite_cmd_scheduler: directed scenarios plus randomized traffic
// scored against a queue-based model of the command/commit ordering rules.
module tb_sprite_cmd_scheduler;

  localparam int DEPTH = 16;
  localparam int VBS   = 480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, wr, rd;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_buf;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  sprite_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .VBLANK_START(VBS)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .chipselect (cs),
    .write      (wr),
    .read       (rd),
    .address    (addr),
    .writedata  (wdata),
    .readdata   (readdata),
    .vcount     (vcount),
    .cmd_out    (cmd_out),
    .front_buf  (front_buf),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          c;
    logic [31:0] w;
  } ent_t;

  ent_t mq[$];
  bit   m_front, m_ovf, m_irq, m_rd_prev, m_swapped;
  int   elig_wait;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_front   = 1'b0;
    m_ovf     = 1'b0;
    m_irq     = 1'b0;
    m_rd_prev = 1'b0;
    m_swapped = 1'b0;
    elig_wait = 0;
  endtask

  // One clock: DUT samples the driven inputs at posedge, the model and checks run at negedge.
  task automatic tick();
    bit psh, isc, clr, rds, pop, swapped, drop, hc, elig;
    logic [31:0] w, exp;
    int len0;
    psh = cs && wr && (addr == 2'd0 || addr == 2'd1);
    isc = (addr == 2'd1);
    w   = wdata;
    clr = cs && wr && (addr == 2'd2);
    rds = cs && rd;
    @(posedge clk);
    @(negedge clk);
    len0    = mq.size();
    hc      = 1'b0;
    if (len0 > 0) hc = mq[0].c;
    elig    = hc && (vcount >= 10'(VBS)) && !m_swapped;
    pop     = (cmd_out !== 32'h0);
    swapped = 1'b0;
    if (len0 > 0 && !hc) chk({31'b0, pop}, 32'd1, "throughput");
    if (pop) begin
      if (len0 == 0) begin
        chk(cmd_out, 32'h0, "spurious_cmd");
      end else if (hc) begin
        chk(cmd_out, {11'b0, 4'hF, 3'b0, ~m_front, 13'b0}, "swap_word");
        chk({31'b0, (vcount >= 10'(VBS)) && !m_swapped}, 32'd1, "swap_window");
        m_front = ~m_front;
        swapped = 1'b1;
        void'(mq.pop_front());
      end else begin
        exp     = mq[0].w;
        exp[13] = ~m_front;
        chk(cmd_out, exp, "cmd_word");
        void'(mq.pop_front());
      end
    end
    if (elig && !pop) elig_wait++;
    else              elig_wait = 0;
    chk({31'b0, elig_wait >= 2}, 32'd0, "swap_latency");
    if (swapped) m_swapped = 1'b1;
    else if (vcount < 10'(VBS)) m_swapped = 1'b0;
    drop = psh && (len0 == DEPTH) && !pop;
    if (psh && !drop) mq.push_back('{c: isc, w: isc ? 32'h0 : w});
    m_ovf     = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_irq     = swapped ? 1'b1 : ((clr || m_rd_prev) ? 1'b0 : m_irq);
    m_rd_prev = rds;
    chk({24'b0, readdata[15:8]}, 32'(mq.size()), "fifo_count");
    chk({31'b0, front_buf}, {31'b0, m_front}, "front_buf");
    chk({31'b0, readdata[2]}, {31'b0, m_front}, "status_front");
    chk({31'b0, readdata[1]}, {31'b0, m_ovf}, "overflow");
    chk({31'b0, readdata[3]}, {31'b0, hc && !pop}, "swap_wait");
`ifdef SPRITE_SCHED_IRQ_EN
    chk({30'b0, irq, readdata[0]}, {30'b0, m_irq, m_irq}, "irq");
`else
    chk({30'b0, irq, readdata[0]}, 32'd0, "irq_off");
`endif
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] w);
    cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = w;
    tick();
  endtask

  task automatic push_commit();
    cs = 1'b1; wr = 1'b1; addr = 2'd1; wdata = $urandom;
    tick();
  endtask

  task automatic clear_flags();
    cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = $urandom;
    tick();
  endtask

  task automatic walk(input int from, input int to, input int step);
    for (int v = from; v <= to; v += step) begin
      vcount = 10'(v);
      tick();
    end
  endtask

  initial begin
    logic [31:0] c0, c1, c2, a, b;
    bit f0;
    int r, guard;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = 32'h0; vcount = 10'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk(cmd_out, 32'h0, "rst_cmd_out");
    chk(readdata, 32'h0, "rst_status");
    chk({30'b0, front_buf, irq}, 32'h0, "rst_front_irq");
    rst_n = 1'b1;

    // 1: three commands drain back to back, retargeted to back buffer 1
    vcount = 10'd100;
    c0 = 32'h0400_0A01; c1 = 32'h0822_1F03; c2 = 32'hFC1C_0005;
    push_cmd(c0); chk(cmd_out, 32'h0, "t1_idle0");
    push_cmd(c1); chk(cmd_out, c0 | 32'h2000, "t1_c0");
    push_cmd(c2); chk(cmd_out, c1 | 32'h2000, "t1_c1");
    tick();       chk(cmd_out, c2 | 32'h2000, "t1_c2");
    tick();       chk(cmd_out, 32'h0, "t1_idle1");

    // 2: A drains, commit waits for line 480, B follows into new back buffer
    a = 32'h1234_0001; b = 32'h4321_2003;
    push_cmd(a); push_commit(); push_cmd(b);
    repeat (3) tick();
    chk(readdata[15:8], 8'd2, "t2_held");
    vcount = 10'd480;
    tick();
    chk(cmd_out, 32'h001E_2000, "t2_swap");
    chk({31'b0, front_buf}, 32'd1, "t2_front");
    tick();
    chk(cmd_out, b & ~32'h2000, "t2_b");
    rd = 1'b1; cs = 1'b1; tick();
    tick();

    // 3: two back-to-back commits swap on two successive vblanks
    vcount = 10'd100;
    push_commit(); push_commit();
    f0 = m_front;
    walk(150, 470, 80);
    walk(480, 520, 10);
    chk({31'b0, front_buf}, {31'b0, ~f0}, "t3_first");
    walk(0, 470, 80);
    walk(480, 520, 10);
    chk({31'b0, front_buf}, {31'b0, f0}, "t3_second");
    vcount = 10'd0; tick();

    // 4: commit reaching the head mid-vblank swaps within 2 cycles
    vcount = 10'd500;
    f0 = m_front;
    push_commit();
    tick(); tick();
    chk({31'b0, front_buf}, {31'b0, ~f0}, "t4_quick_swap");
    vcount = 10'd0; tick();

    // 5: overflow behind a held commit
    vcount = 10'd100;
    push_commit();
    for (int i = 0; i < 17; i++) push_cmd($urandom | 32'h1);
    chk(readdata[15:8], 8'd16, "t5_count");
    chk({31'b0, readdata[1]}, 32'd1, "t5_ovf_set");
    clear_flags();
    chk({31'b0, readdata[1]}, 32'd0, "t5_ovf_clr");
    vcount = 10'd480;
    repeat (20) tick();
    chk(readdata[15:8], 8'd0, "t5_drained");
    vcount = 10'd0; tick();

    // 6: reset while waiting on a commit discards everything
    vcount = 10'd100;
    push_commit();
    for (int i = 0; i < 4; i++) push_cmd($urandom | 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk(cmd_out, 32'h0, "t6_cmd");
    chk(readdata[15:8], 8'd0, "t6_count");
    chk({31'b0, front_buf}, 32'd0, "t6_front");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    walk(100, 520, 20);
    chk({31'b0, front_buf}, 32'd0, "t6_no_swap");
    vcount = 10'd0; tick();

    // Randomized traffic with a fast-scrolling beam
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom % 100);
      if (r < 45)      begin cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = $urandom | 32'h1; end
      else if (r < 52) begin cs = 1'b1; wr = 1'b1; addr = 2'd1; wdata = $urandom; end
      else if (r < 57) begin cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = $urandom; end
      else if (r < 65) begin cs = 1'b1; rd = 1'b1; addr = 2'($urandom); end
      tick();
      vcount = 10'((int'(vcount) + 8) % 525);
    end

    guard = 0;
    while (mq.size() > 0 && guard < 3000) begin
      tick();
      vcount = 10'((int'(vcount) + 8) % 525);
      guard++;
    end
    chk(32'(mq.size()), 32'd0, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
